// File: rtl/mem_bus_pkg.sv
// Shared types for the memory-bus initiator.
//   op_e    : command opcode (read / write)
//   state_e : initiator FSM states
//   cmd_t   : one buffered command {op, addr, wdata}
//   MEM_ADDR_W / MEM_DATA_W : default bus widths shared with the memory model
package mem_bus_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;
  // Wide enough for the largest supported read latency (7).
  localparam int LAT_W      = 3;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD,
    RD_WAIT,
    RESP
  } state_e;

  typedef struct packed {
    op_e                   op;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Command FIFO for the memory-bus initiator.
//   clk, rst : clock, asynchronous active-high reset (flushes pointers only)
//   push/din : write din when not full
//   pop/dout : dout shows the oldest entry; pop discards it when not empty
//   full     : registered, DEPTH entries held
//   empty    : registered, no entries held
module mem_cmd_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output logic full,
  output logic empty,
  output cmd_t dout
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push_en;
  logic             pop_en;

  // A push is refused while full, regardless of a simultaneous pop.
  assign push_en = push && !full_reg;
  assign pop_en  = pop && !empty_reg;

  always_comb begin
    count_next = count_reg;
    if (push_en && !pop_en) begin
      count_next = count_reg + 1'b1;
    end else if (!push_en && pop_en) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == (PTR_W+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_reg[wr_ptr_reg] <= din;
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/mem_bus_master.sv
// Memory-bus initiator: buffers commands, strobes the memory, returns reads.
//   clk, rst                  : clock, asynchronous active-high reset
//   cmd_valid/ready/wr/addr/wdata : command port (valid/ready)
//   mem_wr/rd/addr/wdata/rdata    : memory strobes and data
//   rsp_valid/ready/addr/rdata    : read response port (valid/ready)
//   busy                      : FIFO non-empty or FSM active
//   wr_count / rd_count       : wrapping completion counters
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  state_e             state_reg, state_next;
  logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
  logic               mem_wr_reg, mem_wr_next;
  logic               mem_rd_reg, mem_rd_next;
  logic [ADDR_W-1:0]  mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]  mem_wdata_reg, mem_wdata_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [ADDR_W-1:0]  rsp_addr_reg, rsp_addr_next;
  logic [DATA_W-1:0]  rsp_rdata_reg, rsp_rdata_next;
  logic               busy_reg, busy_next;
  logic [15:0]        wr_count_reg, wr_count_next;
  logic [15:0]        rd_count_reg, rd_count_next;
  // Holds cmd_ready low until the first clock after reset is released.
  logic               ready_en_reg;

  logic fifo_push, fifo_pop, fifo_full, fifo_empty;
  cmd_t fifo_din, fifo_dout;

  assign cmd_ready = ready_en_reg && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  always_comb begin
    fifo_din       = '0;
    fifo_din.op    = cmd_wr ? OP_WR : OP_RD;
    fifo_din.addr  = cmd_addr;
    fifo_din.wdata = cmd_wdata;
  end

  mem_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_comb begin
    state_next     = state_reg;
    lat_cnt_next   = lat_cnt_reg;
    mem_wr_next    = 1'b0;
    mem_rd_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_addr_next  = rsp_addr_reg;
    rsp_rdata_next = rsp_rdata_reg;
    wr_count_next  = wr_count_reg;
    rd_count_next  = rd_count_reg;
    fifo_pop       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          mem_addr_next  = fifo_dout.addr;
          mem_wdata_next = fifo_dout.wdata;
          // Strobes are registered, so they appear in the cycle after the pop.
          if (fifo_dout.op == OP_WR) begin
            state_next  = ISSUE_WR;
            mem_wr_next = 1'b1;
          end else begin
            state_next  = ISSUE_RD;
            mem_rd_next = 1'b1;
          end
        end
      end
      ISSUE_WR: begin
        wr_count_next = wr_count_reg + 16'd1;
        state_next    = IDLE;
      end
      ISSUE_RD: begin
        lat_cnt_next = LAT_W'(RD_LAT);
        state_next   = RD_WAIT;
      end
      RD_WAIT: begin
        // Count value 1 marks the cycle in which mem_rdata is valid.
        if (lat_cnt_reg == LAT_W'(1)) begin
          rsp_rdata_next = mem_rdata;
          rsp_addr_next  = mem_addr_reg;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          rsp_valid_next = 1'b0;
          rd_count_next  = rd_count_reg + 16'd1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A pop always leaves IDLE, so "FIFO non-empty next cycle or FSM busy next
    // cycle" reduces to this without needing the FIFO's next occupancy.
    busy_next = (state_next != IDLE) || fifo_push || !fifo_empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= '0;
      mem_wr_reg    <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_addr_reg  <= '0;
      rsp_rdata_reg <= '0;
      busy_reg      <= 1'b0;
      wr_count_reg  <= '0;
      rd_count_reg  <= '0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lat_cnt_reg   <= lat_cnt_next;
      mem_wr_reg    <= mem_wr_next;
      mem_rd_reg    <= mem_rd_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_addr_reg  <= rsp_addr_next;
      rsp_rdata_reg <= rsp_rdata_next;
      busy_reg      <= busy_next;
      wr_count_reg  <= wr_count_next;
      rd_count_reg  <= rd_count_next;
      ready_en_reg  <= 1'b1;
    end
  end

  assign mem_wr    = mem_wr_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_addr  = rsp_addr_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign busy      = busy_reg;
  assign wr_count  = wr_count_reg;
  assign rd_count  = rd_count_reg;

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_valid3, cmd_wr, rsp_ready;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_wdata;

  logic        cmd_ready, mem_wr, mem_rd, rsp_valid, busy;
  logic [3:0]  mem_addr, rsp_addr;
  logic [7:0]  mem_wdata, mem_rdata, rsp_rdata;
  logic [15:0] wr_count, rd_count;

  logic        cmd_ready3, mem_wr3, mem_rd3, rsp_valid3, busy3;
  logic [3:0]  mem_addr3, rsp_addr3;
  logic [7:0]  mem_wdata3, mem_rdata3, rsp_rdata3;
  logic [15:0] wr_count3, rd_count3;

  always #5 clk = ~clk;

  mem_bus_master #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata), .busy(busy),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  mem_bus_master #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_wr(mem_wr3), .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr3), .rsp_rdata(rsp_rdata3), .busy(busy3),
    .wr_count(wr_count3), .rd_count(rd_count3)
  );

  // Memory responders: data valid RD_LAT cycles after the mem_rd cycle, 0 otherwise.
  logic [7:0] mem1 [16];
  logic [7:0] mem3 [16];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  always @(posedge clk) begin
    if (mem_wr) mem1[mem_addr] <= mem_wdata;
    pipe1 <= mem_rd ? mem1[mem_addr] : 8'h00;
    if (mem_wr3) mem3[mem_addr3] <= mem_wdata3;
    pipe3[0] <= mem_rd3 ? mem3[mem_addr3] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } txn_t;

  typedef struct {
    txn_t t;
    int   cyc;
  } obs_t;

  txn_t exp_strobe_q[$];
  txn_t exp_rsp_q[$];
  obs_t obs_strobe_q[$];
  obs_t obs_rsp_q[$];
  int   obs_rd3_q[$];
  obs_t obs_rsp3_q[$];
  logic [7:0] sb_mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;
  int cyc      = 0;
  int both_seen = 0;
  int busy_fall_cyc = -1;
  logic busy_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation log, sampled mid-cycle.
  always @(negedge clk) begin
    obs_t o;
    if (mem_wr && mem_rd) both_seen++;
    if (mem_wr3 && mem_rd3) both_seen++;
    if (mem_wr || mem_rd) begin
      o.t.wr = mem_wr; o.t.addr = mem_addr; o.t.data = mem_wdata; o.cyc = cyc;
      obs_strobe_q.push_back(o);
    end
    if (rsp_valid && rsp_ready) begin
      o.t.wr = 1'b0; o.t.addr = rsp_addr; o.t.data = rsp_rdata; o.cyc = cyc;
      obs_rsp_q.push_back(o);
    end
    if (mem_rd3) obs_rd3_q.push_back(cyc);
    if (rsp_valid3 && rsp_ready) begin
      o.t.wr = 1'b0; o.t.addr = rsp_addr3; o.t.data = rsp_rdata3; o.cyc = cyc;
      obs_rsp3_q.push_back(o);
    end
    if (busy_d && !busy) busy_fall_cyc = cyc;
    busy_d = busy;
  end

  // Drives one command for one cycle; track=1 records the expected effects.
  task automatic push_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d, input bit track);
    txn_t e;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (track) begin
      e.wr = wr; e.addr = a; e.data = d;
      exp_strobe_q.push_back(e);
      if (wr) begin
        sb_mem[a] = d;
        exp_wr++;
      end else begin
        e.data = sb_mem[a];
        exp_rsp_q.push_back(e);
        exp_rd++;
      end
    end
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_valid3 = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata, rsp_valid, rsp_addr, rsp_rdata, busy,
         wr_count, rd_count, cmd_ready} !== 61'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required=0 (cmd_ready=%b busy=%b)", {mem_wr, mem_rd,
               mem_addr, mem_wdata, rsp_valid, rsp_addr, rsp_rdata, busy, wr_count, rd_count,
               cmd_ready}, cmd_ready, busy);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, cmd_ready3} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_cmd_ready got=%b%b required=11", cmd_ready, cmd_ready3);
    end
    exp_wr = 0; exp_rd = 0;
    $display("reset done");
  endtask

  task automatic test_single_write();
    push_cmd(1'b1, 4'h3, 8'hA5, 1'b1);
    n_checks++;
    if (mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL single_wr_early mem_wr=%b required=0", mem_wr);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h3, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_wr_strobe got wr=%b rd=%b addr=%h data=%h required wr=1 rd=0 addr=3 data=a5",
               mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_wr, rsp_valid, busy} !== 3'b000 || wr_count !== 16'(exp_wr)) begin
      n_fail++;
      $display("FAIL single_wr_after wr=%b rsp_valid=%b busy=%b wr_count=%0d required 0 0 0 %0d",
               mem_wr, rsp_valid, busy, wr_count, exp_wr);
    end
    $display("txn write addr=3 data=a5 wr_count=%0d", wr_count);
    exp_strobe_q.delete(); obs_strobe_q.delete();
  endtask

  task automatic test_readback();
    bit to; txn_t e; obs_t o; int rd_cyc;
    rd_cyc = -100;
    rsp_ready = 1'b1;
    push_cmd(1'b1, 4'h5, 8'h3C, 1'b1);
    push_cmd(1'b0, 4'h5, 8'h00, 1'b1);
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL readback_timeout busy=%b required=0", busy); end
    while (exp_strobe_q.size() > 0) begin
      e = exp_strobe_q.pop_front();
      n_checks++;
      if (obs_strobe_q.size() == 0) begin
        n_fail++; $display("FAIL readback_strobe missing, required wr=%b addr=%h", e.wr, e.addr);
      end else begin
        o = obs_strobe_q.pop_front();
        $display("txn strobe wr=%b addr=%h data=%h cyc=%0d", o.t.wr, o.t.addr, o.t.data, o.cyc);
        if (o.t.wr !== e.wr || o.t.addr !== e.addr || (e.wr && o.t.data !== e.data)) begin
          n_fail++;
          $display("FAIL readback_strobe got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                   o.t.wr, o.t.addr, o.t.data, e.wr, e.addr, e.data);
        end
        if (!e.wr) rd_cyc = o.cyc;
      end
    end
    e = exp_rsp_q.pop_front();
    n_checks++;
    if (obs_rsp_q.size() == 0) begin
      n_fail++; $display("FAIL readback_rsp missing, required addr=%h data=%h", e.addr, e.data);
    end else begin
      o = obs_rsp_q.pop_front();
      $display("txn rsp addr=%h data=%h cyc=%0d", o.t.addr, o.t.data, o.cyc);
      if (o.t.addr !== e.addr || o.t.data !== e.data) begin
        n_fail++;
        $display("FAIL readback_rsp got addr=%h data=%h required addr=%h data=%h",
                 o.t.addr, o.t.data, e.addr, e.data);
      end
      n_checks++;
      if (o.cyc - rd_cyc != 2) begin
        n_fail++; $display("FAIL readback_latency got=%0d required=2", o.cyc - rd_cyc);
      end
    end
    n_checks++;
    if (rd_count !== 16'(exp_rd)) begin
      n_fail++; $display("FAIL readback_rd_count got=%0d required=%0d", rd_count, exp_rd);
    end
  endtask

  task automatic test_backpressure();
    bit to; bit seen; txn_t e; obs_t o;
    rsp_ready = 1'b0;
    push_cmd(1'b0, 4'h5, 8'h00, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_rsp_valid timeout got=0 required=1"); end
    push_cmd(1'b1, 4'h9, 8'h11, 1'b1);
    push_cmd(1'b0, 4'h9, 8'h00, 1'b1);
    push_cmd(1'b1, 4'hA, 8'h22, 1'b1);
    push_cmd(1'b0, 4'h3, 8'h00, 1'b1);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_cmd_ready got=%b required=0", cmd_ready);
    end
    // Offer one more command while full; it must never be accepted.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'hF; cmd_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({rsp_valid, rsp_addr, rsp_rdata} !== {1'b1, 4'h5, 8'h3C}) begin
        n_fail++;
        $display("FAIL bp_rsp_hold got valid=%b addr=%h data=%h required valid=1 addr=5 data=3c",
                 rsp_valid, rsp_addr, rsp_rdata);
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (obs_strobe_q.size() != 1 || rd_count !== 16'(exp_rd - 3)) begin
      n_fail++;
      $display("FAIL bp_stall strobes=%0d rd_count=%0d required strobes=1 rd_count=%0d",
               obs_strobe_q.size(), rd_count, exp_rd - 3);
    end
    rsp_ready = 1'b1;
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bp_timeout busy=%b required=0", busy); end
    while (exp_strobe_q.size() > 0) begin
      e = exp_strobe_q.pop_front();
      n_checks++;
      if (obs_strobe_q.size() == 0) begin
        n_fail++; $display("FAIL bp_strobe missing, required wr=%b addr=%h", e.wr, e.addr);
      end else begin
        o = obs_strobe_q.pop_front();
        $display("txn strobe wr=%b addr=%h data=%h cyc=%0d", o.t.wr, o.t.addr, o.t.data, o.cyc);
        if (o.t.wr !== e.wr || o.t.addr !== e.addr || (e.wr && o.t.data !== e.data)) begin
          n_fail++;
          $display("FAIL bp_strobe got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                   o.t.wr, o.t.addr, o.t.data, e.wr, e.addr, e.data);
        end
      end
    end
    n_checks++;
    if (obs_strobe_q.size() != 0) begin
      n_fail++; $display("FAIL bp_extra_strobe got=%0d required=0", obs_strobe_q.size());
    end
    while (exp_rsp_q.size() > 0) begin
      e = exp_rsp_q.pop_front();
      n_checks++;
      if (obs_rsp_q.size() == 0) begin
        n_fail++; $display("FAIL bp_rsp missing, required addr=%h data=%h", e.addr, e.data);
      end else begin
        o = obs_rsp_q.pop_front();
        $display("txn rsp addr=%h data=%h cyc=%0d", o.t.addr, o.t.data, o.cyc);
        if (o.t.addr !== e.addr || o.t.data !== e.data) begin
          n_fail++;
          $display("FAIL bp_rsp got addr=%h data=%h required addr=%h data=%h",
                   o.t.addr, o.t.data, e.addr, e.data);
        end
      end
    end
    n_checks++;
    if (rd_count !== 16'(exp_rd) || wr_count !== 16'(exp_wr)) begin
      n_fail++;
      $display("FAIL bp_counts got wr=%0d rd=%0d required wr=%0d rd=%0d",
               wr_count, rd_count, exp_wr, exp_rd);
    end
  endtask

  task automatic test_latency();
    obs_t o;
    rsp_ready = 1'b1;
    cmd_valid3 = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h0; cmd_wdata = 8'h77;
    @(posedge clk); #1;
    cmd_wr = 1'b0; cmd_wdata = 8'h00;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!busy3) break;
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs_rd3_q.size() != 1 || obs_rsp3_q.size() != 1) begin
      n_fail++;
      $display("FAIL lat3_events got rd=%0d rsp=%0d required rd=1 rsp=1",
               obs_rd3_q.size(), obs_rsp3_q.size());
    end else begin
      o = obs_rsp3_q.pop_front();
      $display("txn lat3 rsp addr=%h data=%h cyc=%0d", o.t.addr, o.t.data, o.cyc);
      n_checks++;
      if (o.cyc - obs_rd3_q[0] != 4) begin
        n_fail++; $display("FAIL lat3_latency got=%0d required=4", o.cyc - obs_rd3_q[0]);
      end
      n_checks++;
      if (o.t.addr !== 4'h0 || o.t.data !== 8'h77) begin
        n_fail++;
        $display("FAIL lat3_data got addr=%h data=%h required addr=0 data=77", o.t.addr, o.t.data);
      end
    end
    n_checks++;
    if (wr_count3 !== 16'd1 || rd_count3 !== 16'd1) begin
      n_fail++;
      $display("FAIL lat3_counts got wr=%0d rd=%0d required wr=1 rd=1", wr_count3, rd_count3);
    end
  endtask

  task automatic test_reset_mid_read();
    bit to; obs_t o; txn_t e;
    rsp_ready = 1'b1;
    obs_strobe_q.delete(); obs_rsp_q.delete();
    push_cmd(1'b0, 4'h9, 8'h00, 1'b0);
    push_cmd(1'b1, 4'h1, 8'h12, 1'b0);
    push_cmd(1'b1, 4'h2, 8'h34, 1'b0);
    // Now one cycle after the mem_rd strobe, i.e. waiting for read data.
    n_checks++;
    if (obs_strobe_q.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_setup strobes=%0d required=1", obs_strobe_q.size());
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata, rsp_valid, rsp_addr, rsp_rdata, busy,
         wr_count, rd_count, cmd_ready} !== 61'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got=%h required=0 (busy=%b)", {mem_wr, mem_rd, mem_addr,
               mem_wdata, rsp_valid, rsp_addr, rsp_rdata, busy, wr_count, rd_count, cmd_ready}, busy);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    exp_wr = 0; exp_rd = 0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (obs_rsp_q.size() != 0 || obs_strobe_q.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_dropped rsp=%0d strobes=%0d busy=%b required rsp=0 strobes=1 busy=0",
               obs_rsp_q.size(), obs_strobe_q.size(), busy);
    end
    obs_strobe_q.delete(); obs_rsp_q.delete();
    push_cmd(1'b0, 4'h9, 8'h00, 1'b1);
    wait_idle(to);
    exp_strobe_q.delete(); obs_strobe_q.delete();
    e = exp_rsp_q.pop_front();
    n_checks++;
    if (to || obs_rsp_q.size() != 1) begin
      n_fail++; $display("FAIL rst_mid_newread got rsp=%0d required=1", obs_rsp_q.size());
    end else begin
      o = obs_rsp_q.pop_front();
      $display("txn rsp addr=%h data=%h cyc=%0d", o.t.addr, o.t.data, o.cyc);
      if (o.t.addr !== e.addr || o.t.data !== e.data || rd_count !== 16'(exp_rd)) begin
        n_fail++;
        $display("FAIL rst_mid_newread got addr=%h data=%h rd_count=%0d required addr=%h data=%h rd_count=%0d",
                 o.t.addr, o.t.data, rd_count, e.addr, e.data, exp_rd);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to; txn_t e; obs_t o; int prev_cyc;
    prev_cyc = -1;
    obs_strobe_q.delete();
    push_cmd(1'b1, 4'hB, 8'h01, 1'b1);
    push_cmd(1'b1, 4'hC, 8'h02, 1'b1);
    push_cmd(1'b1, 4'hD, 8'h03, 1'b1);
    push_cmd(1'b1, 4'hE, 8'h04, 1'b1);
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL b2b_timeout busy=%b required=0", busy); end
    while (exp_strobe_q.size() > 0) begin
      e = exp_strobe_q.pop_front();
      n_checks++;
      if (obs_strobe_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_strobe missing, required addr=%h", e.addr);
      end else begin
        o = obs_strobe_q.pop_front();
        $display("txn strobe wr=%b addr=%h data=%h cyc=%0d", o.t.wr, o.t.addr, o.t.data, o.cyc);
        if (o.t.wr !== 1'b1 || o.t.addr !== e.addr || o.t.data !== e.data ||
            (prev_cyc >= 0 && o.cyc - prev_cyc != 2)) begin
          n_fail++;
          $display("FAIL b2b_strobe got addr=%h data=%h gap=%0d required addr=%h data=%h gap=2",
                   o.t.addr, o.t.data, o.cyc - prev_cyc, e.addr, e.data);
        end
        prev_cyc = o.cyc;
      end
    end
    n_checks++;
    if (busy_fall_cyc - prev_cyc != 1) begin
      n_fail++; $display("FAIL b2b_busy_fall got=%0d required=1", busy_fall_cyc - prev_cyc);
    end
    n_checks++;
    if (wr_count !== 16'(exp_wr) || obs_strobe_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_wr_count got=%0d extra=%0d required=%0d extra=0",
               wr_count, obs_strobe_q.size(), exp_wr);
    end
    n_checks++;
    if (both_seen != 0) begin
      n_fail++; $display("FAIL strobe_exclusive got=%0d required=0", both_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sb_mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_readback();
    test_backpressure();
    test_latency();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
